// File: rtl/seq_alu.sv
// seq_alu: registered, parametrised 8-op ALU with accumulate chaining and a
// multi-cycle shift-add multiplier.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset (priority over everything)
//   start    request, only sampled in IDLE
//   s        opcode, latched with start
//   a, b     operands, latched with start
//   acc_src  latched with start; 1 selects the acc register as operand A
//   busy     high while an op is in flight (EXEC or MUL)
//   done     one-cycle pulse, results valid
//   acc      result / low half of product
//   mulh     high half of product (written only by multiply)
//   flag     status byte {acc_ones, acc_zero, borrow, carry, a[0], a[msb], a_ones, a_zero}
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_src,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mulh,
  output logic [7:0]       flag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  // operation captured at the latch edge; inputs are don't-care afterwards
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t             state, state_n;
  req_t               req, req_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH-1:0]   acc_n, mulh_n, res;
  logic [7:0]         flag_n;
  logic [WIDTH:0]     sum, diff, madd;

  function automatic logic [7:0] mkflag(logic [WIDTH-1:0] ea, logic [WIDTH-1:0] r,
                                        logic cy, logic bw);
    return {&r, ~|r, bw, cy, ea[0], ea[WIDTH-1], &ea, ~|ea};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= '0;
      cnt   <= '0;
      prod  <= '0;
      acc   <= '0;
      mulh  <= '0;
      flag  <= '0;
    end else begin
      state <= state_n;
      req   <= req_n;
      cnt   <= cnt_n;
      prod  <= prod_n;
      acc   <= acc_n;
      mulh  <= mulh_n;
      flag  <= flag_n;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = req;
    cnt_n   = cnt;
    prod_n  = prod;
    acc_n   = acc;
    mulh_n  = mulh;
    flag_n  = flag;
    res     = '0;
    sum     = {1'b0, req.a} + {1'b0, req.b};
    diff    = {1'b0, req.a} - {1'b0, req.b};
    // right-shift multiply: upper half accumulates, one product bit drops
    // into the lower half per step; after WIDTH steps prod = A*B
    madd    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (req.b[cnt] ? req.a : '0)};

    case (state)
      IDLE: if (start) begin
        req_n.op = s;
        req_n.a  = acc_src ? acc : a;
        req_n.b  = b;
        if (s == 3'b111) begin
          state_n = MUL;
          cnt_n   = '0;
          prod_n  = '0;
        end else begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        case (req.op)
          3'b000:  res = req.a & req.b;
          3'b001:  res = req.a | req.b;
          3'b010:  res = ~req.a;
          3'b011:  res = {req.a[WIDTH-2:0], 1'b0};
          3'b100:  res = {1'b0, req.a[WIDTH-1:1]};
          3'b101:  res = sum[WIDTH-1:0];
          3'b110:  res = diff[WIDTH-1:0];
          default: res = '0;
        endcase
        acc_n   = res;
        flag_n  = mkflag(req.a, res, (req.op == 3'b101) & sum[WIDTH],
                         (req.op == 3'b110) & diff[WIDTH]);
        state_n = DONE;
      end
      MUL: begin
        prod_n = {madd, prod[WIDTH-1:1]};
        cnt_n  = cnt + 1'b1;
        // partials stay internal; outputs change only on the final step
        if (cnt == LAST) begin
          {mulh_n, acc_n} = prod_n;
          flag_n  = mkflag(req.a, prod_n[WIDTH-1:0], 1'b0, 1'b0);
          cnt_n   = '0;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // decoded from the state register only, so no input-to-output path
  assign busy = (state == EXEC) || (state == MUL);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic       clk, rst, start, acc_src;
  logic [2:0] s;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] acc, mulh, flag;

  int vecs = 0;
  int errs = 0;
  int cyc, nb;
  bit held, ovl;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .s(s), .a(a), .b(b), .acc_src(acc_src),
    .busy(busy), .done(done), .acc(acc), .mulh(mulh), .flag(flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic o, input logic e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] o, input logic [7:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chki(input string tag, input int o, input int e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // drive a request and leave at E0+1 with start released
  task automatic go(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                    input logic src);
    s = op; a = av; b = bv; acc_src = src; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // from E0+1: count cycles to done (bounded), busy samples, acc holding, busy&done overlap
  task automatic wait_done(input logic [7:0] hold, output int c, output int n,
                           output bit h, output bit ov);
    c = 0; n = 0; h = 1'b1; ov = 1'b0;
    if (busy) n++;
    if (acc !== hold) h = 1'b0;
    while (!done && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (busy) begin
        n++;
        if (acc !== hold) h = 1'b0;
      end
      if (busy && done) ov = 1'b1;
    end
    chk1("done_seen", done, 1'b1);
  endtask

  // DONE lasts one cycle; afterwards the ALU is back in IDLE
  task automatic end_op(input string tag);
    @(posedge clk); #1;
    chk1(tag, done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s = '0; a = '0; b = '0; acc_src = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk8("rst_acc", acc, 8'h00);
    chk8("rst_mulh", mulh, 8'h00);
    chk8("rst_flag", flag, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // FF*FF = FE01
    go(3'b111, 8'hFF, 8'hFF, 1'b0);
    wait_done(8'h00, cyc, nb, held, ovl);
    chki("mul_lat", cyc, 8);
    chki("mul_busy_cycles", nb, 8);
    chk1("mul_partials_hidden", held, 1'b1);
    chk1("mul_busy_done_overlap", ovl, 1'b0);
    chk8("mul_mulh", mulh, 8'hFE);
    chk8("mul_acc", acc, 8'h01);
    chk8("mul_flag", flag, 8'h0E);
    end_op("mul_done_1cyc");

    // FF+01: carry out, zero result, mulh untouched
    go(3'b101, 8'hFF, 8'h01, 1'b0);
    chk1("add_busy", busy, 1'b1);
    wait_done(8'h01, cyc, nb, held, ovl);
    chki("add_lat", cyc, 1);
    chki("add_busy_cycles", nb, 1);
    chk8("add_acc", acc, 8'h00);
    chk8("add_flag", flag, 8'h5E);
    chk8("add_mulh_held", mulh, 8'hFE);
    end_op("add_done_1cyc");

    // 03-05: borrow
    go(3'b110, 8'h03, 8'h05, 1'b0);
    wait_done(8'h00, cyc, nb, held, ovl);
    chk8("sub_acc", acc, 8'hFE);
    chk8("sub_flag", flag, 8'h28);
    end_op("sub_end");

    go(3'b000, 8'hF0, 8'h3C, 1'b0);
    wait_done(8'hFE, cyc, nb, held, ovl);
    chk8("and_acc", acc, 8'h30);
    chk8("and_flag", flag, 8'h04);
    end_op("and_end");

    go(3'b010, 8'h00, 8'h5A, 1'b0);
    wait_done(8'h30, cyc, nb, held, ovl);
    chk8("not_acc", acc, 8'hFF);
    chk8("not_flag", flag, 8'h81);
    end_op("not_end");

    // FF*00
    go(3'b111, 8'hFF, 8'h00, 1'b0);
    wait_done(8'hFF, cyc, nb, held, ovl);
    chki("mul0_lat", cyc, 8);
    chk1("mul0_partials_hidden", held, 1'b1);
    chk8("mul0_mulh", mulh, 8'h00);
    chk8("mul0_acc", acc, 8'h00);
    chk8("mul0_flag", flag, 8'h4E);
    end_op("mul0_end");

    // chaining on acc
    go(3'b001, 8'h81, 8'h00, 1'b0);
    wait_done(8'h00, cyc, nb, held, ovl);
    chk8("or_acc", acc, 8'h81);
    chk8("or_flag", flag, 8'h0C);
    end_op("or_end");

    go(3'b011, 8'h00, 8'h00, 1'b1);
    wait_done(8'h81, cyc, nb, held, ovl);
    chk8("shl_acc", acc, 8'h02);
    chk8("shl_flag", flag, 8'h0C);
    end_op("shl_end");

    go(3'b100, 8'hFF, 8'h00, 1'b1);
    wait_done(8'h02, cyc, nb, held, ovl);
    chk8("shr_acc", acc, 8'h01);
    chk8("shr_flag", flag, 8'h00);
    end_op("shr_end");

    // start held during MUL and DONE: ignored until IDLE
    go(3'b111, 8'h10, 8'h20, 1'b0);
    s = 3'b101; a = 8'h11; b = 8'h22; acc_src = 1'b0; start = 1'b1;
    wait_done(8'h01, cyc, nb, held, ovl);
    chki("sb_lat", cyc, 8);
    chk8("sb_acc", acc, 8'h00);
    chk8("sb_mulh", mulh, 8'h02);
    chk8("sb_flag", flag, 8'h40);
    @(posedge clk); #1;
    chk1("sb_no_extra_done", done, 1'b0);
    chk1("sb_idle_not_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk1("sb_latched_in_idle", busy, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    chk1("sb_add_done", done, 1'b1);
    chk8("sb_add_acc", acc, 8'h33);
    chk8("sb_add_flag", flag, 8'h08);
    chk8("sb_add_mulh", mulh, 8'h02);
    end_op("sb_end");

    // reset during multiply iteration 4
    go(3'b111, 8'hFF, 8'hFF, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk8("rm_hidden", acc, 8'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk8("rm_acc", acc, 8'h00);
    chk8("rm_mulh", mulh, 8'h00);
    chk8("rm_flag", flag, 8'h00);
    chk1("rm_busy", busy, 1'b0);
    chk1("rm_done", done, 1'b0);

    // acc_src right after reset: A = 0
    go(3'b001, 8'h55, 8'h00, 1'b1);
    wait_done(8'h00, cyc, nb, held, ovl);
    chk8("src0_acc", acc, 8'h00);
    chk8("src0_flag", flag, 8'h41);
    end_op("src0_end");

    go(3'b101, 8'h10, 8'h20, 1'b0);
    wait_done(8'h00, cyc, nb, held, ovl);
    chk8("post_add_acc", acc, 8'h30);
    chk8("post_add_flag", flag, 8'h00);
    chk8("post_add_mulh", mulh, 8'h00);
    end_op("post_add_end");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
